// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller for the single-cycle MIPS core: mask, priority select,
// handler entry (EPC/vector) and eret return. Define VIC_EDGE_EN for edge-triggered sticky pending.
module vectored_int_ctrl #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] mask_wd_i,
  input  logic               eret_i,
  input  logic [31:0]        pc_next_i,
  output logic               int_take_o,
  output logic [31:0]        vec_pc_o,
  output logic [31:0]        epc_o,
  output logic               ie_o,
  output logic [2:0]         cause_o,
  output logic [NUM_IRQ-1:0] ack_o,
  output logic [NUM_IRQ-1:0] mask_o
);

  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cause_q, cause_d;
  logic [31:0]        epc_q, epc_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pending, eligible, ack;
  logic [2:0]         winner;

`ifdef VIC_EDGE_EN
  logic [NUM_IRQ-1:0] irq_q, pend_q, pend_d;

  // ack clears only at the end of TAKE; a fresh rising edge in that cycle re-arms the line.
  always_comb pend_d = (pend_q & ~ack) | (irq_i & ~irq_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;
`else
  assign pending = irq_i;
`endif

  assign eligible = pending & mask_q;

  // Scanning downward leaves the lowest set index as the last assignment.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    mask_d  = mask_we_i ? mask_wd_i : mask_q;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          cause_d = winner;
          state_d = TAKE;
        end
      end
      TAKE: begin
        epc_d   = pc_next_i;
        state_d = SERVICE;
      end
      SERVICE: begin
        if (eret_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack[i] = (state_q == TAKE) && (cause_q == 3'(i));
    end
  end

  assign int_take_o = (state_q == TAKE);
  assign vec_pc_o   = int_take_o ? (VEC_BASE + ({29'd0, cause_q} * 32'(VEC_STRIDE))) : 32'd0;
  assign epc_o      = epc_q;
  assign ie_o       = (state_q == IDLE);
  assign cause_o    = cause_q;
  assign ack_o      = ack;
  assign mask_o     = mask_q;

endmodule
